// File: rtl/sd_arb_pkg.sv
// Shared types and defaults for the SD byte-FIFO arbiter (sd_fifo_arbiter, sd_arb_cnt).
// Optional watchdog is enabled with the SD_ARB_WATCHDOG_EN macro.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN0    = 2'd1,
        OWN1    = 2'd2,
        HANDOFF = 2'd3
    } arb_state_t;

    localparam int DEF_BLOCK_BYTES = 512;
    localparam int DEF_TIMEOUT     = 4096;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;

endpackage

// File: rtl/sd_arb_cnt.sv
// Holder byte counter with block-end detect; optional idle watchdog (SD_ARB_WATCHDOG_EN).
// Registered counts, combinational last/timeout flags; no flow control of its own.
module sd_arb_cnt
    import sd_arb_pkg::*;
#(
    parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
    parameter int CNT_W       = $clog2(BLOCK_BYTES)
`ifdef SD_ARB_WATCHDOG_EN
    ,
    parameter int TIMEOUT     = DEF_TIMEOUT
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             last
`ifdef SD_ARB_WATCHDOG_EN
    ,
    input  logic             own,
    output logic             timeout
`endif
);

    assign last = (byte_cnt == CNT_W'(BLOCK_BYTES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt <= '0;
        end else if (clr) begin
            byte_cnt <= '0;
        end else if (inc) begin
            byte_cnt <= last ? '0 : byte_cnt + 1'b1;
        end
    end

`ifdef SD_ARB_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [WD_W-1:0] wd_cnt;

    // Counts consecutive strobe-free ownership cycles; any non-owning state clears it.
    assign timeout = own && !inc && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (!own || inc) begin
            wd_cnt <= '0;
        end else if (!timeout) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/sd_fifo_arbiter.sv
// Round-robin owner of the SD controller byte-FIFO port between SPI link (0) and FPGA engine (1).
// Grant 1 cycle after request, zero-latency strobe/data pass-through; yields at block ends. Watchdog: SD_ARB_WATCHDOG_EN.
module sd_fifo_arbiter
    import sd_arb_pkg::*;
#(
    parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
    parameter int CNT_W       = $clog2(BLOCK_BYTES)
`ifdef SD_ARB_WATCHDOG_EN
    ,
    parameter int TIMEOUT     = DEF_TIMEOUT
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    output logic             gnt0,
    output logic             gnt1,
    input  logic             rd_en0,
    input  logic             rd_en1,
    input  logic             wr_en0,
    input  logic             wr_en1,
    input  logic [7:0]       wr_dat0,
    input  logic [7:0]       wr_dat1,
    output logic [7:0]       rd_dat0,
    output logic [7:0]       rd_dat1,
    output logic             rd_en,
    output logic             wr_en,
    output logic [7:0]       wr_dat,
    input  logic [7:0]       rd_dat,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             err
`ifdef SD_ARB_WATCHDOG_EN
    ,
    output logic             wdog_to
`endif
);

    arb_state_t state, state_nxt;
    logic       rr;
    logic       stb0, stb1;
    logic       inc, last, clr, timeout;

    assign gnt0 = (state == OWN0);
    assign gnt1 = (state == OWN1);

    assign stb0 = rd_en0 | wr_en0;
    assign stb1 = rd_en1 | wr_en1;
    assign inc  = (gnt0 & stb0) | (gnt1 & stb1);
    assign clr  = (state == IDLE) && (state_nxt != IDLE);

    assign rd_en   = (gnt0 & rd_en0) | (gnt1 & rd_en1);
    assign wr_en   = (gnt0 & wr_en0) | (gnt1 & wr_en1);
    assign wr_dat  = gnt1 ? wr_dat1 : wr_dat0;
    assign rd_dat0 = gnt0 ? rd_dat : 8'h00;
    assign rd_dat1 = gnt1 ? rd_dat : 8'h00;

    sd_arb_cnt #(
        .BLOCK_BYTES (BLOCK_BYTES),
        .CNT_W       (CNT_W)
`ifdef SD_ARB_WATCHDOG_EN
        ,
        .TIMEOUT     (TIMEOUT)
`endif
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .inc      (inc),
        .byte_cnt (byte_cnt),
        .last     (last)
`ifdef SD_ARB_WATCHDOG_EN
        ,
        .own      (gnt0 | gnt1),
        .timeout  (timeout)
`endif
    );

`ifndef SD_ARB_WATCHDOG_EN
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1) state_nxt = rr ? OWN1 : OWN0;
                else if (req0)    state_nxt = OWN0;
                else if (req1)    state_nxt = OWN1;
            end
            // Yield at a block end only if the other port is actually waiting.
            OWN0: if (!req0 || (stb0 && last && req1) || timeout) state_nxt = HANDOFF;
            OWN1: if (!req1 || (stb1 && last && req0) || timeout) state_nxt = HANDOFF;
            HANDOFF: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rr    <= 1'(PORT0);
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clr) rr <= (state_nxt == OWN0) ? 1'(PORT1) : 1'(PORT0);
            if ((stb0 && !gnt0) || (stb1 && !gnt1)) err <= 1'b1;
        end
    end

`ifdef SD_ARB_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (!rst_n)       wdog_to <= 1'b0;
        else if (timeout) wdog_to <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_sd_fifo_arbiter.sv
// Directed self-checking bench for sd_fifo_arbiter; covers the watchdog when SD_ARB_WATCHDOG_EN is defined.
module tb_sd_fifo_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, gnt0, gnt1;
    logic       rd_en0, rd_en1, wr_en0, wr_en1;
    logic [7:0] wr_dat0, wr_dat1, rd_dat0, rd_dat1;
    logic       rd_en, wr_en;
    logic [7:0] wr_dat, rd_dat;
    logic [8:0] byte_cnt;
    logic       err;
`ifdef SD_ARB_WATCHDOG_EN
    logic       wdog_to;
`endif

    int tests  = 0;
    int failed = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int inv_bad = 0;

    always #5 clk = ~clk;

    sd_fifo_arbiter #(
        .BLOCK_BYTES (512),
        .CNT_W       (9)
`ifdef SD_ARB_WATCHDOG_EN
        ,
        .TIMEOUT     (16)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rd_en0   (rd_en0),
        .rd_en1   (rd_en1),
        .wr_en0   (wr_en0),
        .wr_en1   (wr_en1),
        .wr_dat0  (wr_dat0),
        .wr_dat1  (wr_dat1),
        .rd_dat0  (rd_dat0),
        .rd_dat1  (rd_dat1),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .wr_dat   (wr_dat),
        .rd_dat   (rd_dat),
        .byte_cnt (byte_cnt),
        .err      (err)
`ifdef SD_ARB_WATCHDOG_EN
        ,
        .wdog_to  (wdog_to)
`endif
    );

    // Controller-side strobe tally and grant invariants.
    always @(posedge clk) begin
        if (rd_en) rd_cnt <= rd_cnt + 1;
        if (wr_en) wr_cnt <= wr_cnt + 1;
        if (rst_n && (gnt0 && gnt1)) inv_bad <= inv_bad + 1;
        if (rst_n && (rd_en || wr_en) && !(gnt0 || gnt1)) inv_bad <= inv_bad + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int rd0, wr0, drops;
        rst_n = 1'b0; req0 = 0; req1 = 0;
        rd_en0 = 0; rd_en1 = 0; wr_en0 = 0; wr_en1 = 0;
        wr_dat0 = 8'h00; wr_dat1 = 8'h00; rd_dat = 8'h00;
        repeat (3) tick();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_byte_cnt", byte_cnt, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // Single requester, three reads.
        req0 = 1; #1;
        chk("a_gnt0_latency", gnt0, 0);
        tick();
        chk("a_gnt0", gnt0, 1);
        rd0 = rd_cnt;
        rd_dat = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            rd_en0 = 1; #1;
            chk("a_rd_dat0", rd_dat0, 8'hA5);
            chk("a_rd_dat1_zero", rd_dat1, 8'h00);
            tick();
        end
        rd_en0 = 0;
        chk("a_byte_cnt", byte_cnt, 3);
        chk("a_rd_fwd", rd_cnt - rd0, 3);
        req0 = 0;
        tick(); tick(); tick();

        // Simultaneous requests after reset: port 0 first, then port 1 after a 2-cycle gap.
        rst_n = 0; tick(); tick(); rst_n = 1;
        req0 = 1; req1 = 1;
        tick();
        chk("b_gnt0_first", gnt0, 1);
        chk("b_gnt1_first", gnt1, 0);
        for (int i = 0; i < 10; i++) begin
            wr_en0 = 1; wr_dat0 = 8'h10 + 8'(i); #1;
            chk("b_wr_dat", wr_dat, 32'h10 + i);
            tick();
        end
        wr_en0 = 0; req0 = 0;
        tick();
        chk("b_handoff_gnt0", gnt0, 0);
        chk("b_handoff_gnt1", gnt1, 0);
        chk("b_byte_cnt10", byte_cnt, 10);
        tick();
        chk("b_idle_gnt1", gnt1, 0);
        tick();
        chk("b_gnt1", gnt1, 1);
        chk("b_byte_cnt_clr", byte_cnt, 0);
        rd_dat = 8'h3C; #1;
        chk("b_rd_dat1", rd_dat1, 8'h3C);
        chk("b_rd_dat0_zero", rd_dat0, 8'h00);
        req1 = 0;
        tick(); tick();

        // Block-boundary yield with port 1 waiting.
        req0 = 1; req1 = 1;
        tick();
        chk("c_gnt0_rr", gnt0, 1);
        wr0 = wr_cnt;
        for (int i = 0; i < 512; i++) begin
            wr_en0 = 1; #1;
            if (i == 511) chk("c_gnt0_last_byte", gnt0, 1);
            tick();
        end
        wr_en0 = 0;
        chk("c_wr_fwd", wr_cnt - wr0, 512);
        chk("c_yield_gnt0", gnt0, 0);
        chk("c_byte_cnt_wrap", byte_cnt, 0);
        tick();
        chk("c_idle_gnt1", gnt1, 0);
        tick();
        chk("c_gnt1", gnt1, 1);
        chk("c_err_clean", err, 0);
        // Port 0 still waiting; a stray read from it must be blocked and flagged.
        rd_en0 = 1; #1;
        chk("c_stray_rd_blocked", rd_en, 0);
        tick();
        rd_en0 = 0;
        chk("c_err_set", err, 1);
        req1 = 0;
        tick(); tick(); tick();
        chk("c_reacquire_gnt0", gnt0, 1);
        chk("c_reacquire_cnt", byte_cnt, 0);

        // Port 0 alone streams two blocks without yielding.
        rd0 = rd_cnt;
        drops = 0;
        for (int i = 0; i < 1024; i++) begin
            rd_en0 = 1;
            tick();
            if (!gnt0) drops++;
            if (i == 510) chk("d_byte_cnt_511", byte_cnt, 511);
            if (i == 511) chk("d_byte_cnt_wrap", byte_cnt, 0);
        end
        rd_en0 = 0;
        chk("d_no_yield", drops, 0);
        chk("d_rd_fwd", rd_cnt - rd0, 1024);
        chk("d_byte_cnt_end", byte_cnt, 0);
        wr_en1 = 1; wr_dat1 = 8'hFF; #1;
        chk("d_stray_wr_blocked", wr_en, 0);
        tick();
        wr_en1 = 0;
        chk("d_err_sticky", err, 1);
        tick();
        chk("d_err_still", err, 1);

        // Reset clears err and drops the grant on the next edge.
        rst_n = 0;
        tick();
        chk("e_rst_gnt0", gnt0, 0);
        chk("e_rst_err", err, 0);
        req0 = 0; rst_n = 1;
        tick();

        // Reset mid-ownership of port 1.
        req1 = 1;
        tick();
        chk("f_gnt1", gnt1, 1);
        for (int i = 0; i < 5; i++) begin
            wr_en1 = 1;
            tick();
        end
        wr_en1 = 0;
        chk("f_byte_cnt5", byte_cnt, 5);
        rst_n = 0;
        tick();
        chk("f_rst_gnt1", gnt1, 0);
        chk("f_rst_byte_cnt", byte_cnt, 0);
        req1 = 0; rst_n = 1;
        tick(); tick();

`ifdef SD_ARB_WATCHDOG_EN
        chk("w_wdog_reset", wdog_to, 0);
        req0 = 1;
        tick();
        chk("w_gnt0", gnt0, 1);
        for (int i = 0; i < 15; i++) tick();
        chk("w_gnt0_before_to", gnt0, 1);
        chk("w_wdog_before_to", wdog_to, 0);
        tick();
        chk("w_gnt0_revoked", gnt0, 0);
        chk("w_wdog_to", wdog_to, 1);
        tick(); tick();
        chk("w_regrant", gnt0, 1);
        req0 = 0;
        tick(); tick();
`endif

        chk("invariant", inv_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
